drop_ctrl: RTL and testbench

Turn and piece-drop controller for the Connect Four board. It decodes keyboard presses into cursor moves and drops, and tracks per-column fill heights and the player turn. Each frame it animates the falling piece's screen coordinates, then issues a one-cycle board-cell write when the piece lands. It feeds the piece sprite renderer (PieceX/PieceY) and the board-state register file (cell_* write port).

---
 rtl/drop_ctrl.sv | 85 ++++++++
 tb/tb_drop_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/drop_ctrl.sv
// drop_ctrl: Connect Four cursor/turn controller that animates a falling piece and emits a one-cycle board write on landing.
module drop_ctrl #(
  parameter int CELL = 75,
  parameter int X_BASE = 0,
  parameter int Y_BASE = 75,
  parameter int FALL_STEP = 15,
  parameter logic [7:0] KEY_LEFT = 8'h04,
  parameter logic [7:0] KEY_RIGHT = 8'h07,
  parameter logic [7:0] KEY_DROP = 8'h2C
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic [9:0] PieceX,
  output logic [9:0] PieceY,
  output logic [2:0] cur_col,
  output logic       turn,
  output logic       busy,
  output logic       cell_we,
  output logic [2:0] cell_row,
  output logic [2:0] cell_col,
  output logic       cell_player,
  output logic       drop_rej,
  output logic       board_full
);
  localparam logic [1:0] IDLE = 2'd0, FALL = 2'd1, LAND = 2'd2;
  logic [1:0] state;
  logic [7:0] key_prev;
  logic [2:0] height [0:6];
  logic [2:0] tgt_row;
  logic [5:0] count;
  logic       press, act, col_full;
  logic [9:0] tgt_y, next_y;
  assign press = (keycode != 8'd0) && (key_prev == 8'd0);
  assign act = (state == IDLE) && press && !board_full;
  assign col_full = height[cur_col] == 3'd6;
  assign tgt_y = 10'(Y_BASE) + 10'(tgt_row) * 10'(CELL);
  assign next_y = PieceY + 10'(FALL_STEP);
  assign PieceX = 10'(X_BASE) + 10'(cur_col) * 10'(CELL);
  assign busy = state != IDLE;
  assign cell_we = state == LAND;
  assign cell_row = cell_we ? tgt_row : 3'd0;
  assign cell_col = cell_we ? cur_col : 3'd0;
  assign cell_player = cell_we ? turn : 1'b0;
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      key_prev <= 8'd0;
      cur_col <= 3'd0;
      turn <= 1'b0;
      tgt_row <= 3'd0;
      count <= 6'd0;
      PieceY <= 10'd0;
      drop_rej <= 1'b0;
      board_full <= 1'b0;
      for (int i = 0; i < 7; i++) height[i] <= 3'd0;
    end else begin
      key_prev <= keycode;
      drop_rej <= act && keycode == KEY_DROP && col_full;
      case (state)
        IDLE: if (act) begin
          if (keycode == KEY_LEFT && cur_col != 3'd0) cur_col <= cur_col - 3'd1;
          if (keycode == KEY_RIGHT && cur_col != 3'd6) cur_col <= cur_col + 3'd1;
          if (keycode == KEY_DROP && !col_full) begin
            tgt_row <= 3'd5 - height[cur_col];
            state <= FALL;
          end
        end
        FALL: if (next_y >= tgt_y) begin
          PieceY <= tgt_y;
          state <= LAND;
        end else PieceY <= next_y;
        LAND: begin
          height[cur_col] <= height[cur_col] + 3'd1;
          turn <= ~turn;
          PieceY <= 10'd0;
          count <= count + 6'd1;
          board_full <= count == 6'd41;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_drop_ctrl.sv
// tb_drop_ctrl: self-checking bench for drop_ctrl against a column-height/turn reference model.
module tb_drop_ctrl;
  localparam logic [7:0] KL = 8'h04, KR = 8'h07, KD = 8'h2C;
  logic       frame_clk = 1'b0, Reset = 1'b0;
  logic [7:0] keycode = 8'd0;
  logic [9:0] PieceX, PieceY;
  logic [2:0] cur_col, cell_row, cell_col;
  logic       turn, busy, cell_we, cell_player, drop_rej, board_full;
  int errors = 0, checks = 0;
  drop_ctrl dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
    .PieceX(PieceX), .PieceY(PieceY), .cur_col(cur_col), .turn(turn), .busy(busy),
    .cell_we(cell_we), .cell_row(cell_row), .cell_col(cell_col), .cell_player(cell_player),
    .drop_rej(drop_rej), .board_full(board_full)
  );
  always #5 frame_clk = ~frame_clk;
  int m_col, m_turn, m_cnt, m_phase, m_k, m_n, m_row, m_y, m_tgt;
  int m_h [7];
  bit m_full, m_rej;
  logic [7:0] m_prev;
  int wr_seen, wr_row, wr_col, wr_pl;
  logic [34:0] dut_vec;
  assign dut_vec = {PieceX, PieceY, cur_col, turn, busy, cell_we, cell_row, cell_col,
                    cell_player, drop_rej, board_full};
  function automatic logic [34:0] exp_vec();
    logic we;
    we = m_phase == 2;
    return {10'(m_col * 75), 10'(m_y), 3'(m_col), 1'(m_turn), m_phase != 0, we,
            we ? 3'(m_row) : 3'd0, we ? 3'(m_col) : 3'd0, we ? 1'(m_turn) : 1'b0, m_rej, m_full};
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic model_reset();
    m_col = 0; m_turn = 0; m_cnt = 0; m_phase = 0; m_y = 0; m_k = 0; m_n = 0; m_row = 0;
    m_full = 0; m_rej = 0; m_prev = 0;
    foreach (m_h[i]) m_h[i] = 0;
  endtask
  task automatic model_edge(input logic [7:0] k);
    bit press;
    press = k != 0 && m_prev == 0;
    m_prev = k;
    m_rej = 0;
    if (m_phase == 0) begin
      if (press && !m_full) begin
        if (k == KL) m_col = m_col > 0 ? m_col - 1 : 0;
        else if (k == KR) m_col = m_col < 6 ? m_col + 1 : 6;
        else if (k == KD) begin
          if (m_h[m_col] < 6) begin
            m_row = 5 - m_h[m_col];
            m_tgt = 75 + m_row * 75;
            m_n = (m_tgt + 14) / 15;
            m_k = 0;
            m_phase = 1;
          end else m_rej = 1;
        end
      end
    end else if (m_phase == 1) begin
      m_k++;
      if (m_k == m_n) begin m_phase = 2; m_y = m_tgt; end
      else m_y = m_k * 15;
    end else begin
      m_h[m_col]++;
      m_turn ^= 1;
      m_y = 0;
      m_cnt++;
      m_full = m_cnt == 42;
      m_phase = 0;
    end
  endtask
  task automatic step(input logic [7:0] k);
    keycode = k;
    @(posedge frame_clk);
    model_edge(k);
    #1;
    chk("outputs", 64'(dut_vec), 64'(exp_vec()));
    if (cell_we) begin wr_seen++; wr_row = cell_row; wr_col = cell_col; wr_pl = cell_player; end
  endtask
  task automatic move(input logic [7:0] k);
    step(k);
    step(8'd0);
  endtask
  task automatic do_reset();
    @(negedge frame_clk);
    Reset = 1'b0;
    keycode = 8'd0;
    #2;
    chk("reset_state", 64'(dut_vec), 64'd0);
    @(negedge frame_clk);
    Reset = 1'b1;
    model_reset();
  endtask
  task automatic drop_wait(output int nbusy);
    wr_seen = 0;
    step(KD);
    nbusy = 0;
    for (int i = 0; i < 100 && busy; i++) begin
      nbusy++;
      step(8'd0);
    end
    chk("drop_done", 64'(busy), 64'd0);
  endtask
  typedef struct { logic [7:0] key; int col; } vec_t;
  vec_t tbl [10];
  initial begin
    int n;
    tbl = '{'{KR, 1}, '{KR, 1}, '{8'd0, 1}, '{KR, 2}, '{8'd0, 2},
            '{KL, 1}, '{8'd0, 1}, '{KL, 0}, '{8'd0, 0}, '{KL, 0}};
    model_reset();
    #12;
    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].key);
      chk("tbl_col", 64'(cur_col), 64'(tbl[i].col));
      chk("tbl_x", 64'(PieceX), 64'(tbl[i].col * 75));
    end
    // first drop into column 3
    do_reset();
    repeat (3) move(KR);
    chk("col3", 64'(cur_col), 64'd3);
    chk("x225", 64'(PieceX), 64'd225);
    drop_wait(n);
    chk("busy_len", 64'(n), 64'd31);
    chk("wr_once", 64'(wr_seen), 64'd1);
    chk("wr_cell", 64'({wr_row, wr_col, wr_pl}), 64'({32'd5, 32'd3, 32'd0}));
    chk("turn_after", 64'(turn), 64'd1);
    chk("y_after", 64'(PieceY), 64'd0);
    repeat (20) step(KR);
    step(8'd0);
    chk("hold_right", 64'(cur_col), 64'd4);
    repeat (3) move(KR);
    chk("sat_right", 64'(cur_col), 64'd6);
    // stack column 0 then reject
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drop_wait(n);
      chk("stack_cell", 64'({wr_row, wr_col, wr_pl}), 64'({5 - i, 0, i % 2}));
    end
    step(KD);
    chk("rej_pulse", 64'({drop_rej, busy}), 64'({1'b1, 1'b0}));
    step(8'd0);
    chk("rej_end", 64'({drop_rej, busy, turn}), 64'd0);
    // async reset while falling
    do_reset();
    wr_seen = 0;
    step(KD);
    for (int i = 0; i < 40 && PieceY != 10'd210; i++) step(8'd0);
    chk("reach_210", 64'(PieceY), 64'd210);
    #2;
    Reset = 1'b0;
    #1;
    chk("async_y", 64'({PieceY, busy, cell_we}), 64'd0);
    model_reset();
    @(negedge frame_clk);
    Reset = 1'b1;
    chk("no_write", 64'(wr_seen), 64'd0);
    drop_wait(n);
    chk("heights_cleared", 64'(wr_row), 64'd5);
    // fill the whole board
    do_reset();
    for (int c = 0; c < 7; c++) begin
      for (int r = 0; r < 6; r++) drop_wait(n);
      if (c < 6) move(KR);
    end
    chk("full", 64'(board_full), 64'd1);
    move(KL);
    move(KD);
    move(KR);
    chk("full_frozen", 64'({cur_col, busy, drop_rej, turn}), 64'({3'd6, 1'b0, 1'b0, 1'b0}));
    // random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 9);
      step(r < 5 ? 8'd0 : r == 5 ? KL : r == 6 ? KR : r < 9 ? KD : 8'h11);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
